alu_div_seq: RTL and testbench
==============================

# alu_div_seq

Multi-cycle radix-2 restoring divider for the RV64M divide/remainder group: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW. It sits directly beside the execute-stage ALU and takes the same raw `alu_a_i`/`alu_b_i` operands. It returns one 64-bit result over a valid/ready handshake, so execute stalls on it instead of using a single-cycle combinational divide path. One operation is in flight at a time; the pipeline can cancel it with `flush_i`.

## Interface
- `XLEN`, default 64 (from `sysconfig.v`): operand and result width.
- `clk`  in  1  clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  synchronous cancel of any operation.
- `in_valid_i`  in  1  operation request.
- `in_ready_o`  out  1  high only in IDLE.
- `div_a_i`  in  XLEN  dividend, raw register value.
- `div_b_i`  in  XLEN  divisor, raw register value.
- `is_signed_i`  in  1  signed operation (DIV/REM/DIVW/REMW).
- `is_word_i`  in  1  32-bit W-variant operation.
- `is_rem_i`  in  1  return the remainder instead of the quotient.
- `out_valid_o`  out  1  result available.
- `out_ready_i`  in  1  consumer accepts the result.
- `result_o`  out  XLEN  final, already-extended result.

## Operation
- **States:** IDLE, CALC, DONE.
- **Accept:** an operation is accepted on an edge where `in_valid_i && in_ready_o`.
- **Operand capture at accept:** latch the three control flags.
  - Word mode: operands become bits [31:0], sign-extended if signed, else zero-extended.
  - Signed mode: latch the absolute values of the dividend and divisor, and record `neg_q = sa ^ sb` and `neg_r = sa` (sa/sb are the operand sign bits).
  - Iteration count N = 32 (word) or 64.
- **Special cases, resolved at accept (IDLE → DONE directly):**
  - Divisor zero: quotient = all ones; remainder = dividend (after word truncation).
  - Signed overflow (dividend = most negative value, divisor = −1, at the active width): quotient = dividend; remainder = 0.
- **Normal case (IDLE → CALC):**
  - Each CALC cycle performs one restoring step on {rem, quo}: shift left by 1, trial-subtract the divisor, and keep the difference and set the quotient LSB if it is non-negative.
  - After N steps, go to DONE.
  - On the DONE transition, apply sign correction (two's complement when `neg_q`/`neg_r`) and register the selected result.
- **Result formatting:** word-mode results are taken from bits [31:0] and sign-extended to 64 bits for all four W ops, including DIVUW/REMUW.
- **DONE:** `out_valid_o = 1`; `result_o` is stable. Go DONE → IDLE on the edge where `out_ready_i = 1`.
- **`in_ready_o`:** low in CALC and DONE, so a new operation can be accepted no earlier than the cycle after the output handshake.
- **Flush:** `flush_i` forces IDLE from any state; the result is discarded. If flush and a new input coincide in IDLE, the input is not accepted.
- **Reset:** `rst` has priority over flush. After reset: state IDLE, `out_valid_o = 0`, `result_o = 0`, `in_ready_o = 1`. All internal registers clear.
- **Mid-operation reset or flush:** returns to IDLE with no output pulse.

## Timing
- Latency is counted in clock edges from the accept edge to the edge after which `out_valid_o` is high:
  - 64-bit normal: 65.
  - Word normal: 33.
  - Special case: 1.
- `result_o` is registered, with no combinational path from any input to any output.
- `in_ready_o` depends only on state.
- Throughput: one operation per (latency + 1) cycles when `out_ready_i` is held high.
- While `out_ready_i` is low, DONE holds indefinitely with no change to `result_o`.

## Structure
- **Shared defines in `sysconfig.v`:**
  - `XLEN`.
  - `DIVST_IDLE`/`DIVST_CALC`/`DIVST_DONE` as a 2-bit state encoding.
  - `DIV_CNT_LEN` = 7 (counter width).
- **Sub-module `alu_div_step`:** combinational, one iteration. It takes the partial remainder, the quotient and the divisor, and returns the next remainder and quotient.
- **Top level:** holds the FSM, the counter, operand prep, the special-case detection and the sign fix-up.

## Test plan
- DIVU, a = 100, b = 7, `out_ready_i` high → `result_o` = 14 at latency 65; repeat with REMU → 2.
- DIVW, a = 0xFFFFFFFF_FFFFFFF9 (−7), b = 2 → quotient 0xFFFFFFFF_FFFFFFFD at latency 33; REMW with the same operands → 0xFFFFFFFF_FFFFFFFF.
- DIV with b = 0, a = 5 → 0xFFFFFFFF_FFFFFFFF at latency 1; REM with the same operands → 5.
- DIV, a = 0x80000000_00000000, b = −1 → result 0x80000000_00000000 at latency 1; REM with the same operands → 0.
- Start DIVU, assert `flush_i` at cycle 20 → `out_valid_o` never rises and `in_ready_o` = 1 next cycle. Then DIVU 9/3 → 3.
- Hold `out_ready_i` low for 10 cycles after DONE → `out_valid_o` and `result_o` stay stable and `in_ready_o` stays 0. Raising `out_ready_i` returns the block to IDLE the next cycle.

Source files
------------

// File: rtl/alu_div_seq_pkg.sv
// rtl/alu_div_seq_pkg.sv - shared widths, state encoding and result helpers for the sequential divider
package alu_div_seq_pkg;

    localparam int XLEN        = 64;
    localparam int DIV_CNT_LEN = 7;

    typedef enum logic [1:0] {
        DIVST_IDLE = 2'd0,
        DIVST_CALC = 2'd1,
        DIVST_DONE = 2'd2
    } div_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // Every W-variant result, signed or not, is returned sign-extended from bit 31.
    function automatic logic [XLEN-1:0] fmt_result(input logic [XLEN-1:0] v, input logic word);
        return word ? sext32(v[31:0]) : v;
    endfunction

endpackage

// File: rtl/alu_div_seq_if.sv
// rtl/alu_div_seq_if.sv - request/response handshake bundle between execute and the divider
interface alu_div_seq_if;
    import alu_div_seq_pkg::*;

    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] div_a_i;
    logic [XLEN-1:0] div_b_i;
    logic            is_signed_i;
    logic            is_word_i;
    logic            is_rem_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] result_o;

    modport master (
        output in_valid_i, div_a_i, div_b_i, is_signed_i, is_word_i, is_rem_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o
    );

    modport slave (
        input  in_valid_i, div_a_i, div_b_i, is_signed_i, is_word_i, is_rem_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o
    );

endinterface

// File: rtl/alu_div_step.sv
// rtl/alu_div_step.sv - one combinational restoring-division iteration on {rem, quo}
module alu_div_step
    import alu_div_seq_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0]   w_rem_sh;
    logic [XLEN-1:0] w_sub;
    logic            w_ge;

    // Shifted remainder needs one extra bit: an unsigned divisor can exceed 2^(XLEN-1).
    assign w_rem_sh = {i_rem, i_quo[XLEN-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, i_div});
    assign w_sub    = w_rem_sh[XLEN-1:0] - i_div;

    assign o_rem = w_ge ? w_sub : w_rem_sh[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - multi-cycle RV64M divide/remainder unit with valid/ready handshake
module alu_div_seq
    import alu_div_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    alu_div_seq_if.slave  bus
);

    div_state_e             r_state;
    logic [XLEN-1:0]        r_rem;
    logic [XLEN-1:0]        r_quo;
    logic [XLEN-1:0]        r_div;
    logic [DIV_CNT_LEN-1:0] r_cnt;
    logic                   r_word;
    logic                   r_is_rem;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_out_valid;
    logic [XLEN-1:0]        r_result;

    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs;
    logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_q_fix, w_r_fix;
    logic [XLEN-1:0] w_spec_res, w_calc_res, w_min_neg;
    logic            w_sa, w_sb, w_b_zero, w_ovf;

    always_comb begin
        w_a_ext = bus.div_a_i;
        w_b_ext = bus.div_b_i;
        if (bus.is_word_i) begin
            w_a_ext = bus.is_signed_i ? sext32(bus.div_a_i[31:0]) : {{(XLEN-32){1'b0}}, bus.div_a_i[31:0]};
            w_b_ext = bus.is_signed_i ? sext32(bus.div_b_i[31:0]) : {{(XLEN-32){1'b0}}, bus.div_b_i[31:0]};
        end
        w_sa      = bus.is_signed_i & w_a_ext[XLEN-1];
        w_sb      = bus.is_signed_i & w_b_ext[XLEN-1];
        w_a_abs   = w_sa ? -w_a_ext : w_a_ext;
        w_b_abs   = w_sb ? -w_b_ext : w_b_ext;
        w_b_zero  = (w_b_ext == '0);
        w_min_neg = bus.is_word_i ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        w_ovf     = bus.is_signed_i & (&w_b_ext) & (w_a_ext == w_min_neg);
        if (w_b_zero)
            w_spec_res = bus.is_rem_i ? w_a_ext : '1;
        else
            w_spec_res = bus.is_rem_i ? '0 : w_a_ext;
        w_spec_res = fmt_result(w_spec_res, bus.is_word_i);
    end

    alu_div_step u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    assign w_q_fix    = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_r_fix    = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    assign w_calc_res = fmt_result(r_is_rem ? w_r_fix : w_q_fix, r_word);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= DIVST_IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_word      <= 1'b0;
            r_is_rem    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (flush_i) begin
            r_state     <= DIVST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                DIVST_IDLE: begin
                    if (bus.in_valid_i) begin
                        r_word   <= bus.is_word_i;
                        r_is_rem <= bus.is_rem_i;
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        if (w_b_zero || w_ovf) begin
                            r_result    <= w_spec_res;
                            r_out_valid <= 1'b1;
                            r_state     <= DIVST_DONE;
                        end else begin
                            // Word dividends sit in the upper half so 32 shifts consume them fully.
                            r_rem   <= '0;
                            r_quo   <= bus.is_word_i ? (w_a_abs << 32) : w_a_abs;
                            r_div   <= w_b_abs;
                            r_cnt   <= bus.is_word_i ? DIV_CNT_LEN'(32) : DIV_CNT_LEN'(64);
                            r_state <= DIVST_CALC;
                        end
                    end
                end
                DIVST_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == DIV_CNT_LEN'(1)) begin
                        r_result    <= w_calc_res;
                        r_out_valid <= 1'b1;
                        r_state     <= DIVST_DONE;
                    end
                end
                DIVST_DONE: begin
                    if (bus.out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= DIVST_IDLE;
                    end
                end
                default: r_state <= DIVST_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (r_state == DIVST_IDLE);
    assign bus.out_valid_o = r_out_valid;
    assign bus.result_o    = r_result;

endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - directed-vector self-checking bench for alu_div_seq
module tb_alu_div_seq;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    alu_div_seq_if bus ();

    alu_div_seq dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    endtask

    task automatic set_op(input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic w, input logic r);
        bus.div_a_i     = a;
        bus.div_b_i     = b;
        bus.is_signed_i = s;
        bus.is_word_i   = w;
        bus.is_rem_i    = r;
    endtask

    // Called #1 after an edge with the unit idle; returns #1 after the final edge.
    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input logic w, input logic r,
                         input logic [63:0] exp, input int exp_lat);
        int lat;
        set_op(a, b, s, w, r);
        bus.in_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        lat = 1;
        while (!bus.out_valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, bus.result_o, exp);
        if (bus.out_ready_i) begin
            @(posedge clk); #1;
            check({tag, "_idle"}, {62'b0, bus.in_ready_o, bus.out_valid_o}, 64'b10);
        end
    endtask

    initial begin
        logic [63:0] held;
        logic        stable;
        int          seen;

        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        set_op(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.in_ready_o), 64'd1);
        check("rst_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_result", bus.result_o, 64'd0);
        rst = 1'b0;

        do_op("divu",   64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 65);
        do_op("remu",   64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 64'd2, 65);
        do_op("divw",   64'hFFFFFFFF_FFFFFFF9, 64'd2, 1'b1, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFD, 33);
        do_op("remw",   64'hFFFFFFFF_FFFFFFF9, 64'd2, 1'b1, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 33);
        do_op("div0",   64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1);
        do_op("rem0",   64'd5, 64'd0, 1'b1, 1'b0, 1'b1, 64'd5, 1);
        do_op("divovf", 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0, 1'b0, 64'h80000000_00000000, 1);
        do_op("removf", 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0, 1'b1, 64'd0, 1);
        do_op("divneg", 64'hFFFFFFFF_FFFFFF9C, 64'd7, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFF2, 65);
        do_op("remneg", 64'hFFFFFFFF_FFFFFF9C, 64'd7, 1'b1, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFE, 65);
        do_op("divubig", 64'hFFFFFFFF_FFFFFFFF, 64'd2, 1'b0, 1'b0, 1'b0, 64'h7FFFFFFF_FFFFFFFF, 65);
        do_op("divuw",  64'h00000000_FFFFFFFE, 64'd1, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFE, 33);
        do_op("remuw",  64'h12345678_00000007, 64'h00000001_00000003, 1'b0, 1'b1, 1'b1, 64'd1, 33);
        do_op("divwovf", 64'h00000000_80000000, 64'h00000000_FFFFFFFF, 1'b1, 1'b1, 1'b0, 64'hFFFFFFFF_80000000, 1);
        do_op("divuw0", 64'd9, 64'h00000001_00000000, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1);
        do_op("remuw0", 64'h00000000_80000000, 64'd0, 1'b0, 1'b1, 1'b1, 64'hFFFFFFFF_80000000, 1);

        // Flush 20 cycles into an operation.
        set_op(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0);
        bus.in_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ready", 64'(bus.in_ready_o), 64'd1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.out_valid_o) seen++;
            @(posedge clk); #1;
        end
        check("flush_noout", 64'(seen), 64'd0);

        // Flush coinciding with a request must drop the request.
        flush = 1'b1;
        bus.in_valid_i = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        check("flush_drop", 64'(bus.in_ready_o), 64'd1);
        do_op("div93", 64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 64'd3, 65);

        // Back-pressure: DONE holds while out_ready_i is low.
        bus.out_ready_i = 1'b0;
        do_op("hold", 64'd20, 64'd6, 1'b0, 1'b0, 1'b0, 64'd3, 65);
        held = bus.result_o;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!bus.out_valid_o || bus.in_ready_o || bus.result_o !== held) stable = 1'b0;
        end
        check("hold_stable", 64'(stable), 64'd1);
        check("hold_result", bus.result_o, 64'd3);
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        check("hold_release", {62'b0, bus.in_ready_o, bus.out_valid_o}, 64'b10);

        // Reset in the middle of a calculation.
        set_op(64'd50, 64'd5, 1'b0, 1'b0, 1'b0);
        bus.in_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_state", {62'b0, bus.in_ready_o, bus.out_valid_o}, 64'b10);
        check("midrst_result", bus.result_o, 64'd0);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            if (bus.out_valid_o) seen++;
            @(posedge clk); #1;
        end
        check("midrst_noout", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
